back_end_native_arbiter: RTL and testbench

//  Shares one native back-end memory port between the cache write channel (write-through word
//  or write-back line burst) and the read channel (line fill). Grants whole bursts atomically.

---
 rtl/back_end_native_arbiter.sv | 77 +++++++
 tb/tb_back_end_native_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/back_end_native_arbiter.sv
// back_end_native_arbiter: shares one native memory port between a write channel and a line-fill read channel with atomic burst grants
`timescale 1ns/1ps
module back_end_native_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int WRITE_POL     = 0,
  parameter int LINE2MEM_W    = 3,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_wdata,
  input  logic [DATA_W/8-1:0] w_wstrb,
  output logic                w_ready,
  input  logic                r_valid,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_rdata,
  output logic                r_ready,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);
  localparam int CW = LINE2MEM_W > 0 ? LINE2MEM_W : 1;
  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [CW-1:0] R_LAST = CW'((2 ** LINE2MEM_W) - 1);
  localparam logic [CW-1:0] W_LAST = WRITE_POL != 0 ? R_LAST : '0;
  localparam logic [SW-1:0] S_MAX = SW'(MAX_WR_STREAK);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] streak, streak_n;
  logic beat, last;
  assign r_rdata = mem_rdata;
  // state, beat counter and write streak registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      streak <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      streak <= streak_n;
    end
  end
  // port muxing for the granted channel, idle arbitration and burst tracking
  always_comb begin
    mem_valid = state == WRITE ? w_valid : state == READ ? r_valid : 1'b0;
    mem_addr  = state == WRITE ? w_addr : state == READ ? r_addr : '0;
    mem_wdata = state == WRITE ? w_wdata : '0;
    mem_wstrb = state == WRITE ? w_wstrb : '0;
    w_ready   = state == WRITE && mem_ready;
    r_ready   = state == READ && mem_ready;
    beat      = mem_valid && mem_ready;
    last      = beat && cnt == (state == WRITE ? W_LAST : R_LAST);
    state_n   = state;
    cnt_n     = cnt;
    streak_n  = streak;
    if (state == IDLE) begin
      if (w_valid && !(r_valid && streak == S_MAX)) begin
        state_n  = WRITE;
        streak_n = r_valid ? (streak == S_MAX ? streak : streak + 1'b1) : '0;
      end else if (r_valid) begin
        state_n  = READ;
        streak_n = '0;
      end
    end else if (beat) begin
      cnt_n   = last ? '0 : cnt + 1'b1;
      state_n = last ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_back_end_native_arbiter.sv
// tb_back_end_native_arbiter: directed and random checks of a write-through and a write-back arbiter against a burst-level model
`timescale 1ns/1ps
module tb_back_end_native_arbiter;
  localparam int MS = 4;
  logic clk = 1'b0;
  logic reset, w_valid, r_valid, mem_ready;
  logic [31:0] w_addr, w_wdata, r_addr, mem_rdata;
  logic [3:0] w_wstrb;
  logic mv[2], wr[2], rr[2];
  logic [31:0] ma[2], mwd[2], rrd[2];
  logic [3:0] mws[2];
  int checks = 0, failures = 0, cyc = 0;
  int g[2], left[2], streak[2], wcnt[2], rcnt[2];
  byte gq[2][$];
  always #5 clk = ~clk;
  back_end_native_arbiter #(.WRITE_POL(0), .LINE2MEM_W(3), .MAX_WR_STREAK(MS)) dut_wt (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_addr(w_addr), .w_wdata(w_wdata), .w_wstrb(w_wstrb), .w_ready(wr[0]),
    .r_valid(r_valid), .r_addr(r_addr), .r_rdata(rrd[0]), .r_ready(rr[0]),
    .mem_valid(mv[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_wstrb(mws[0]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));
  back_end_native_arbiter #(.WRITE_POL(1), .LINE2MEM_W(3), .MAX_WR_STREAK(MS)) dut_wb (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_addr(w_addr), .w_wdata(w_wdata), .w_wstrb(w_wstrb), .w_ready(wr[1]),
    .r_valid(r_valid), .r_addr(r_addr), .r_rdata(rrd[1]), .r_ready(rr[1]),
    .mem_valid(mv[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_wstrb(mws[1]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));
  // burst-level model: grant 0 none / 1 write / 2 read, beats remaining, write streak
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        g[d] = 0; left[d] = 0; streak[d] = 0;
      end else if (g[d] == 0) begin
        if (w_valid && !(r_valid && streak[d] == MS)) begin
          g[d] = 1; left[d] = d == 1 ? 8 : 1;
          streak[d] = r_valid ? (streak[d] < MS ? streak[d] + 1 : MS) : 0;
        end else if (r_valid) begin
          g[d] = 2; left[d] = 8; streak[d] = 0;
        end
      end else if ((g[d] == 1 ? w_valid : r_valid) && mem_ready) begin
        left[d]--;
        if (left[d] == 0) g[d] = 0;
      end
    end
  endtask
  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      logic [102:0] obs, exp;
      obs = {mv[d], ma[d], g[d] == 2 ? 32'h0 : mwd[d], mws[d], wr[d], rr[d], rrd[d]};
      exp = {g[d] == 1 ? w_valid : g[d] == 2 ? r_valid : 1'b0,
             g[d] == 1 ? w_addr : g[d] == 2 ? r_addr : 32'h0,
             g[d] == 1 ? w_wdata : 32'h0,
             g[d] == 1 ? w_wstrb : 4'h0,
             g[d] == 1 && mem_ready, g[d] == 2 && mem_ready, mem_rdata};
      checks++;
      assert (obs === exp) else begin
        failures++;
        $error("FAIL outputs dut%0d cycle %0d: got %h expected %h", d, cyc, obs, exp);
      end
      if (wr[d]) begin wcnt[d]++; gq[d].push_back("W"); end
      if (rr[d]) begin rcnt[d]++; gq[d].push_back("R"); end
    end
  endtask
  task automatic tick();
    mem_rdata = $urandom;
    #1 check_cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask
  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0; rcnt[d] = 0; gq[d].delete();
    end
  endtask
  task automatic reset_pulse();
    w_valid = 0; r_valid = 0; mem_ready = 0; reset = 0;
    tick();
    reset = 1;
    clear_stats();
  endtask
  initial begin
    string seq;
    reset = 0; w_valid = 1; r_valid = 1; mem_ready = 0;
    w_addr = 32'h100; w_wdata = $urandom; w_wstrb = 4'hf; r_addr = 32'h2000; mem_rdata = 0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick();
    tick();
    #1 expect_eq("reset_mem_valid", mv[0], 0);
    expect_eq("reset_readies", {wr[0], rr[0], wr[1], rr[1]}, 0);
    reset_pulse();
    w_valid = 1; w_addr = 32'h100; w_wstrb = 4'b0011; w_wdata = $urandom;
    tick();
    mem_ready = 1;
    #1 expect_eq("wt_valid_after_grant", mv[0], 1);
    expect_eq("wt_wstrb", mws[0], 4'h3);
    tick();
    w_valid = 0; mem_ready = 0;
    tick();
    tick();
    #1 expect_eq("wt_ready_pulses", wcnt[0], 1);
    expect_eq("wt_idle_after", mv[0], 0);
    reset_pulse();
    r_valid = 1; r_addr = 32'h4000;
    for (int i = 0; i < 40; i++) begin
      mem_ready = i[0];
      if (rcnt[0] >= 8) r_valid = 0;
      tick();
    end
    expect_eq("fill_pulses_wt", rcnt[0], 8);
    expect_eq("fill_pulses_wb", rcnt[1], 8);
    #1 expect_eq("fill_idle", mv[0], 0);
    reset_pulse();
    w_valid = 1; r_valid = 1; mem_ready = 1;
    repeat (24) tick();
    seq = "WWWWRRRRRRRRW";
    for (int i = 0; i < seq.len(); i++) expect_eq($sformatf("streak_seq_%0d", i), gq[0].size() > i ? gq[0][i] : 8'h0, seq[i]);
    reset_pulse();
    w_valid = 1; mem_ready = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) r_valid = 1;
      if (wcnt[1] >= 8) w_valid = 0;
      tick();
    end
    seq = "WWWWWWWWR";
    for (int i = 0; i < seq.len(); i++) expect_eq($sformatf("wb_burst_seq_%0d", i), gq[1].size() > i ? gq[1][i] : 8'h0, seq[i]);
    reset_pulse();
    r_valid = 1; mem_ready = 1;
    tick();
    tick();
    tick();
    reset = 0;
    tick();
    reset = 1;
    #1 expect_eq("abort_idle", mv[0], 0);
    expect_eq("abort_beats_before", rcnt[0], 3);
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      if (rcnt[0] >= 8) r_valid = 0;
      tick();
    end
    expect_eq("refill_pulses_wt", rcnt[0], 8);
    expect_eq("refill_pulses_wb", rcnt[1], 8);
    reset_pulse();
    for (int i = 0; i < 600; i++) begin
      w_valid = $urandom_range(0, 3) != 0;
      r_valid = $urandom_range(0, 2) != 0;
      mem_ready = $urandom_range(0, 3) != 0;
      w_addr = $urandom; w_wdata = $urandom; w_wstrb = 4'($urandom); r_addr = $urandom;
      reset = $urandom_range(0, 59) != 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
